ft_meta_wrr_arbiter: RTL and testbench
======================================

// Module: ft_meta_wrr_arbiter
// PURPOSE
//  Weighted round-robin arbiter that shares the flow table's single metadata input among N_REQ requesters.
//  Requesters are fresh parser metadata, reinjected reorder metadata and forwarded metadata.
//  Each metadata word is one flit, so arbitration is per flit; a holder keeps the grant for up to WEIGHT flits.
//  Output is registered through a 2-entry skid buffer; per-requester accept counters feed the stats path.
// PARAMETERS
//  N_REQ    3                 number of requesters (2..8)
//  DW       512               metadata word width in bits
//  WEIGHTS  {4'd1,4'd1,4'd4}  packed 4 bits per requester, req0 in LSBs; weight 0 is treated as 1
// PORTS
//  Clk              in   1         single clock
//  Rst_n            in   1         asynchronous, active-low reset
//  in_data          in   N_REQ*DW  requester i data in bits [i*DW +: DW]
//  in_valid         in   N_REQ     per-requester valid
//  in_ready         out  N_REQ     per-requester ready; at most one bit set
//  out_data         out  DW        to flow table in_meta.data
//  out_valid        out  1         registered valid
//  out_ready        in   1         flow table ready
//  out_almost_full  in   1         downstream almost full; blocks new accepts
//  stats_req_cnt    out  N_REQ*32  accepted flits per requester, wraps at 2^32
//  stats_out_cnt    out  32        out_valid & out_ready handshakes, wraps at 2^32
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - out_valid=0, out_data=0, in_ready=0, all stats=0.
//   - Skid buffer empty, FSM=IDLE, ptr=0, credit=0.
//  FSM states:
//   - IDLE: no holder. Choose first i with in_valid[i], searching from ptr in round-robin order.
//     Set holder=i, credit=WEIGHT[i], go to GRANT (1 cycle, no accept this cycle).
//     Stay in IDLE if no valid.
//   - GRANT: in_ready[holder] = buffer_has_space & ~out_almost_full.
//     An accept (in_valid & in_ready) writes in_data[holder] to the buffer and decrements credit.
//     Leave GRANT when credit reaches 0 after an accept, or when in_valid[holder]=0 with no accept:
//       - ptr=holder+1 (mod N_REQ).
//       - Select the next valid requester from ptr this same cycle; reload credit from its weight.
//       - Stay in GRANT with the new holder; go to IDLE if none is valid.
//  Flow control:
//   - Valid never depends on ready.
//   - Holder data must stay stable while valid and not ready; this is the requester's obligation.
//   - Non-holders see ready=0.
//  Latency: a flit accepted in cycle t shows on out_valid in t+1 when the buffer was empty.
//  Throughput: 1 flit/cycle sustained while out_ready=1.
//  Skid buffer:
//   - buffer_has_space = occupancy<2 registered as a flag; no combinational out_ready->in_ready path.
//   - Push and pop in the same cycle leave occupancy unchanged; order is FIFO.
//  out_almost_full=1: no new accepts; buffered entries still drain.
//   - Holder and credit are held; the grant is not forfeited.
//  Arithmetic:
//   - credit is 4 bits.
//   - Counters are 32-bit and wrap silently.
//   - A requester count increments on its accept; stats_out_cnt increments on out handshake; both same cycle.
//  Reset asserted mid-burst discards buffered flits; no partial state survives.
// TESTING
//  - Reset: Rst_n=0 for 3 cycles with in_valid=3'b111 -> in_ready=0, out_valid=0, stats=0.
//  - Weighting: all three valid continuously, out_ready=1 -> out order r0 x4, r1, r2, repeating.
//    After 60 flits: counts 40/10/10.
//  - Early yield: r0 valid for 2 flits then drops, r1 valid -> r1 granted right after r0's 2nd accept cycle.
//    No IDLE bubble.
//  - Backpressure: out_ready=0 after 1 flit -> exactly 2 flits buffered and in_ready drops.
//    out_ready=1 -> FIFO order kept, no loss or duplication.
//  - Almost full: out_almost_full=1 for 5 cycles during r0 burst (credit 2 left) -> no accepts.
//    Release -> r0 sends its remaining 2 flits before r1.
//  - Wrap: preload stats_req_cnt[0] to 32'hFFFFFFFF, accept 1 flit -> 0; stats_out_cnt tracks independently.

Source files
------------

// File: rtl/ft_meta_wrr_arbiter_if.sv
// Metadata arbitration bus: N_REQ requester ports in, one flow-table port out, plus stats.
// The master side drives requester data and downstream flow control; the slave side is the arbiter.
interface ft_meta_wrr_arbiter_if #(
    parameter int N_REQ = 3,
    parameter int DW    = 512
);
    logic [N_REQ*DW-1:0] in_data;
    logic [N_REQ-1:0]    in_valid;
    logic [N_REQ-1:0]    in_ready;
    logic [DW-1:0]       out_data;
    logic                out_valid;
    logic                out_ready;
    logic                out_almost_full;
    logic [N_REQ*32-1:0] stats_req_cnt;
    logic [31:0]         stats_out_cnt;

    modport master (
        output in_data, in_valid, out_ready, out_almost_full,
        input  in_ready, out_data, out_valid, stats_req_cnt, stats_out_cnt
    );

    modport slave (
        input  in_data, in_valid, out_ready, out_almost_full,
        output in_ready, out_data, out_valid, stats_req_cnt, stats_out_cnt
    );
endinterface

// File: rtl/ft_meta_wrr_arbiter.sv
// Weighted round-robin arbiter feeding flow-table metadata through a 2-entry output skid buffer.
//   state | meaning
//   IDLE  | no holder; search for a valid requester from ptr, grant next cycle
//   GRANT | holder owns in_ready until its credit is spent or it drops valid
module ft_meta_wrr_arbiter #(
    parameter int                 N_REQ       = 3,
    parameter int                 DW          = 512,
    parameter logic [4*N_REQ-1:0] WEIGHTS     = {4'd1, 4'd1, 4'd4},
    parameter logic [31:0]        REQ_CNT_RST = 32'd0
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    ft_meta_wrr_arbiter_if.slave bus
);
    localparam int PW = $clog2(N_REQ);

    typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_e;

    state_e         state_q;
    logic [PW-1:0]  holder_q;
    logic [PW-1:0]  ptr_q;
    logic [3:0]     credit_q;

    logic [DW-1:0]  buf_q [2];
    logic           wr_ptr_q;
    logic           rd_ptr_q;
    logic [1:0]     occ_q;
    logic           space_q;
    logic           out_valid_q;

    logic [31:0]    req_cnt_q [N_REQ];
    logic [31:0]    out_cnt_q;

    logic [N_REQ-1:0]    hold_oh;
    logic [N_REQ-1:0]    ready_vec;
    logic                hold_valid;
    logic                accept;
    logic                pop;
    logic                leave;
    logic [DW-1:0]       hold_data;
    logic [1:0]          occ_d;
    logic [PW-1:0]       next_ptr;
    logic [PW:0]         sel_idle;
    logic [PW:0]         sel_next;
    logic [N_REQ*32-1:0] stats_flat;

    function automatic logic [3:0] weight_of(input logic [PW-1:0] idx);
        logic [3:0] w;
        w = 4'd1;
        for (int j = 0; j < N_REQ; j++) begin
            if (idx == PW'(j)) w = WEIGHTS[j*4 +: 4];
        end
        return (w == 4'd0) ? 4'd1 : w;
    endfunction

    // Returns {found, index} of the first valid requester at or after start, wrapping.
    function automatic logic [PW:0] pick(input logic [N_REQ-1:0] vld, input logic [PW-1:0] start);
        logic [PW:0] res;
        res = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (j == (int'(start) + k) % N_REQ && vld[j]) res = {1'b1, PW'(j)};
            end
        end
        return res;
    endfunction

    always_comb begin
        hold_oh   = '0;
        hold_data = '0;
        for (int j = 0; j < N_REQ; j++) begin
            hold_oh[j] = (holder_q == PW'(j));
            if (holder_q == PW'(j)) hold_data = bus.in_data[j*DW +: DW];
        end
    end

    // Ready is gated only by registered state and almost_full; out_ready never reaches it.
    assign ready_vec  = hold_oh & {N_REQ{(state_q == GRANT) && space_q && !bus.out_almost_full}};
    assign hold_valid = |(hold_oh & bus.in_valid);
    assign accept     = |(ready_vec & bus.in_valid);
    assign pop        = out_valid_q & bus.out_ready;
    assign occ_d      = occ_q + {1'b0, accept} - {1'b0, pop};
    assign next_ptr   = (holder_q == PW'(N_REQ - 1)) ? '0 : holder_q + 1'b1;
    assign sel_idle   = pick(bus.in_valid, ptr_q);
    assign sel_next   = pick(bus.in_valid, next_ptr);
    assign leave      = (state_q == GRANT) &&
                        ((accept && credit_q == 4'd1) || (!hold_valid && !accept));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            holder_q <= '0;
            ptr_q    <= '0;
            credit_q <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel_idle[PW]) begin
                        holder_q <= sel_idle[PW-1:0];
                        credit_q <= weight_of(sel_idle[PW-1:0]);
                        state_q  <= GRANT;
                    end
                end
                GRANT: begin
                    if (leave) begin
                        ptr_q <= next_ptr;
                        if (sel_next[PW]) begin
                            holder_q <= sel_next[PW-1:0];
                            credit_q <= weight_of(sel_next[PW-1:0]);
                        end else begin
                            credit_q <= 4'd0;
                            state_q  <= IDLE;
                        end
                    end else if (accept) begin
                        credit_q <= credit_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            occ_q       <= 2'd0;
            space_q     <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                buf_q[wr_ptr_q] <= hold_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            occ_q       <= occ_d;
            space_q     <= (occ_d < 2'd2);
            out_valid_q <= (occ_d != 2'd0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int j = 0; j < N_REQ; j++) req_cnt_q[j] <= REQ_CNT_RST;
            out_cnt_q <= 32'd0;
        end else begin
            for (int j = 0; j < N_REQ; j++) begin
                if (accept && hold_oh[j]) req_cnt_q[j] <= req_cnt_q[j] + 32'd1;
            end
            if (pop) out_cnt_q <= out_cnt_q + 32'd1;
        end
    end

    always_comb begin
        stats_flat = '0;
        for (int j = 0; j < N_REQ; j++) stats_flat[j*32 +: 32] = req_cnt_q[j];
    end

    assign bus.in_ready      = ready_vec;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_data      = buf_q[rd_ptr_q];
    assign bus.stats_req_cnt = stats_flat;
    assign bus.stats_out_cnt = out_cnt_q;
endmodule

// File: tb/tb_ft_meta_wrr_arbiter.sv
// Scoreboard bench for ft_meta_wrr_arbiter: expected output words queued at stimulus time,
// compared in order as the arbiter hands them to the flow table.
module tb_ft_meta_wrr_arbiter;
    localparam int N  = 3;
    localparam int DW = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ft_meta_wrr_arbiter_if #(.N_REQ(N), .DW(DW)) bus ();
    ft_meta_wrr_arbiter_if #(.N_REQ(N), .DW(DW)) bw ();

    ft_meta_wrr_arbiter #(.N_REQ(N), .DW(DW)) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    ft_meta_wrr_arbiter #(.N_REQ(N), .DW(DW), .REQ_CNT_RST(32'hFFFF_FFFF)) dut_w (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bw)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int seq     = 0;
    int acc_cnt [N];
    int acc_cyc_q [$];
    logic [N-1:0]  en;
    logic [DW-1:0] src_q  [N][$];
    logic [DW-1:0] pend_q [N][$];
    logic [DW-1:0] exp_q  [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input int id);
        seq++;
        return DW'({8'(id), 24'(seq)});
    endfunction

    function automatic int total_acc();
        int s;
        s = 0;
        for (int i = 0; i < N; i++) s += acc_cnt[i];
        return s;
    endfunction

    task automatic load(input int id, input int n);
        logic [DW-1:0] w;
        for (int k = 0; k < n; k++) begin
            w = mk(id);
            src_q[id].push_back(w);
            pend_q[id].push_back(w);
        end
    endtask

    task automatic exp_flits(input int id, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(pend_q[id].pop_front());
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int b;
        b = budget;
        while (exp_q.size() != 0 && b > 0) begin
            tick();
            b--;
        end
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    // Requester model + output monitor: sample at negedge, update requester drive after posedge.
    initial begin
        logic [N-1:0]    acc;
        logic [N-1:0]    v;
        logic [N*DW-1:0] d;
        logic [DW-1:0]   e;
        forever begin
            @(negedge clk);
            acc = bus.in_valid & bus.in_ready;
            if (rst_n) begin
                for (int i = 0; i < N; i++) begin
                    if (acc[i]) begin
                        acc_cnt[i]++;
                        acc_cyc_q.push_back(cyc);
                    end
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_unexpected_out", 64'(exp_q.size()), 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", bus.out_data, e);
                    end
                end
            end
            @(posedge clk);
            #2;
            v = '0;
            d = '0;
            for (int i = 0; i < N; i++) begin
                if (acc[i] && rst_n && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    v[i] = en[i];
                    d[i*DW +: DW] = src_q[i][0];
                end
            end
            bus.in_valid = v;
            bus.in_data  = d;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int b;
        int base0;
        logic [DW-1:0] w;
        logic seen;

        for (int i = 0; i < N; i++) acc_cnt[i] = 0;
        en                  = '0;
        bus.in_valid        = '0;
        bus.in_data         = '0;
        bus.out_ready       = 1'b1;
        bus.out_almost_full = 1'b0;
        bw.in_valid         = '0;
        bw.in_data          = '0;
        bw.out_ready        = 1'b1;
        bw.out_almost_full  = 1'b0;

        // Reset held 3 cycles with every requester valid.
        load(0, 40);
        load(1, 10);
        load(2, 10);
        for (int r = 0; r < 10; r++) begin
            exp_flits(0, 4);
            exp_flits(1, 1);
            exp_flits(2, 1);
        end
        en = 3'b111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_valid_driven", 64'(bus.in_valid), 64'h7);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", bus.out_data, 64'd0);
        chk("rst_out_cnt", 64'(bus.stats_out_cnt), 64'd0);
        for (int i = 0; i < N; i++) chk("rst_req_cnt", 64'(bus.stats_req_cnt[i*32 +: 32]), 64'd0);
        rst_n = 1'b1;
        t0 = cyc;

        // Weighted order r0 x4, r1, r2 at one flit per cycle.
        wait_drain("wrr_drain", 200);
        chk("wrr_cycles", 64'(cyc - t0), 64'd62);
        chk("wrr_cnt_r0", 64'(bus.stats_req_cnt[31:0]), 64'd40);
        chk("wrr_cnt_r1", 64'(bus.stats_req_cnt[63:32]), 64'd10);
        chk("wrr_cnt_r2", 64'(bus.stats_req_cnt[95:64]), 64'd10);
        chk("wrr_out_cnt", 64'(bus.stats_out_cnt), 64'd60);

        // Early yield: r0 stops after 2 flits, r1 takes over without an IDLE cycle.
        tick();
        acc_cyc_q.delete();
        load(0, 2);
        load(1, 2);
        exp_flits(0, 2);
        exp_flits(1, 2);
        wait_drain("yield_drain", 50);
        chk("yield_acc_count", 64'(acc_cyc_q.size()), 64'd4);
        if (acc_cyc_q.size() >= 3) chk("yield_gap", 64'(acc_cyc_q[2] - acc_cyc_q[1]), 64'd2);

        // Backpressure: only the two skid entries fill, then ready drops.
        tick();
        bus.out_ready = 1'b0;
        load(1, 4);
        exp_flits(1, 4);
        b = total_acc();
        repeat (8) tick();
        chk("bp_accepts", 64'(total_acc() - b), 64'd2);
        chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b1;
        wait_drain("bp_drain", 50);
        chk("bp_out_cnt", 64'(bus.stats_out_cnt), 64'd68);

        // Almost-full with r0 holding 2 credits: no accepts, grant kept.
        tick();
        load(0, 4);
        load(1, 2);
        exp_flits(0, 4);
        exp_flits(1, 2);
        base0 = acc_cnt[0];
        b = 30;
        while (acc_cnt[0] - base0 < 2 && b > 0) begin
            tick();
            b--;
        end
        chk("af_prefill", 64'(acc_cnt[0] - base0), 64'd2);
        bus.out_almost_full = 1'b1;
        b = total_acc();
        repeat (2) tick();
        chk("af_in_ready", 64'(bus.in_ready), 64'd0);
        repeat (3) tick();
        chk("af_accepts", 64'(total_acc() - b), 64'd0);
        chk("af_drained", 64'(bus.out_valid), 64'd0);
        bus.out_almost_full = 1'b0;
        wait_drain("af_drain", 50);
        chk("af_cnt_r0", 64'(acc_cnt[0] - base0), 64'd4);

        // Counter wrap on the preset instance.
        w = mk(0);
        bw.in_data  = {128'd0, w};
        bw.in_valid = 3'b001;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (bw.in_ready[0]) seen = 1'b1;
        end
        chk("wrap_ready_seen", 64'(seen), 64'd1);
        @(posedge clk);
        #1;
        bw.in_valid = '0;
        chk("wrap_out_valid", 64'(bw.out_valid), 64'd1);
        chk("wrap_out_data", bw.out_data, w);
        repeat (2) tick();
        chk("wrap_req0", 64'(bw.stats_req_cnt[31:0]), 64'd0);
        chk("wrap_req1", 64'(bw.stats_req_cnt[63:32]), 64'hFFFF_FFFF);
        chk("wrap_out_cnt", 64'(bw.stats_out_cnt), 64'd1);

        // Reset mid-burst discards buffered flits.
        bus.out_ready = 1'b0;
        load(2, 6);
        repeat (6) tick();
        chk("mid_buffered", 64'(bus.out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("mid_rst_out_data", bus.out_data, 64'd0);
        chk("mid_rst_out_cnt", 64'(bus.stats_out_cnt), 64'd0);
        chk("mid_rst_req2", 64'(bus.stats_req_cnt[95:64]), 64'd0);
        src_q[2].delete();
        pend_q[2].delete();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        load(1, 1);
        exp_flits(1, 1);
        wait_drain("post_rst_drain", 30);
        chk("post_rst_req1", 64'(bus.stats_req_cnt[63:32]), 64'd1);
        chk("post_rst_out_cnt", 64'(bus.stats_out_cnt), 64'd1);

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
